// File: rtl/fft4_input_packer.sv
// fft4_input_packer
// Serial-to-4-lane packer feeding a radix-4 DIT butterfly stage.
// A frame of N_POINTS serial samples is written into four banks of
// N_POINTS/4 words. Sample n lands in bank n[top 2 bits] at offset
// n[low LABEL_WIDTH bits]. The frame is then drained one group per cycle,
// and group g presents sample g + k*N_POINTS/4 on lane k.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   in_valid / in_ready   serial sample handshake (ready only while filling)
//   in_last               frame delimiter, checked on accepted samples only
//   in_r, in_i            signed serial sample
//   x0..x3 _r/_i          signed butterfly lane outputs (zero when not valid)
//   lable                 butterfly group index of the current output
//   valid                 4-lane output valid, no backpressure
//   frame_done            pulses with the last group of a frame
//   frame_err             sticky framing error (cleared only by reset)
module fft4_input_packer #(
   parameter int DATA_WIDTH  = 21,
   parameter int N_POINTS    = 8192,
   parameter int LABEL_WIDTH = 11
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_last,
   input  logic signed [DATA_WIDTH-1:0]  in_r,
   input  logic signed [DATA_WIDTH-1:0]  in_i,
   output logic signed [DATA_WIDTH-1:0]  x0_r,
   output logic signed [DATA_WIDTH-1:0]  x0_i,
   output logic signed [DATA_WIDTH-1:0]  x1_r,
   output logic signed [DATA_WIDTH-1:0]  x1_i,
   output logic signed [DATA_WIDTH-1:0]  x2_r,
   output logic signed [DATA_WIDTH-1:0]  x2_i,
   output logic signed [DATA_WIDTH-1:0]  x3_r,
   output logic signed [DATA_WIDTH-1:0]  x3_i,
   output logic [LABEL_WIDTH-1:0]        lable,
   output logic                          valid,
   output logic                          frame_done,
   output logic                          frame_err
);

   localparam int ADDR_WIDTH = LABEL_WIDTH + 2;
   localparam int BANK_DEPTH = N_POINTS / 4;
   localparam logic [ADDR_WIDTH-1:0]  WR_LAST = ADDR_WIDTH'(N_POINTS - 1);
   localparam logic [LABEL_WIDTH-1:0] RD_LAST = LABEL_WIDTH'(BANK_DEPTH - 1);

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t                        state_q, state_d;
   logic [ADDR_WIDTH-1:0]         wr_cnt_q, wr_cnt_d;
   logic [LABEL_WIDTH-1:0]        rd_cnt_q, rd_cnt_d;
   logic [LABEL_WIDTH-1:0]        lable_q, lable_d;
   logic                          valid_q, valid_d;
   logic                          done_q, done_d;
   logic                          err_q, err_d;
   logic signed [DATA_WIDTH-1:0]  xr_q [4];
   logic signed [DATA_WIDTH-1:0]  xr_d [4];
   logic signed [DATA_WIDTH-1:0]  xi_q [4];
   logic signed [DATA_WIDTH-1:0]  xi_d [4];

   // Each word holds {real, imag} of one sample.
   logic [2*DATA_WIDTH-1:0]       bank_mem [4][BANK_DEPTH];

   logic                          accept;
   logic [1:0]                    wr_bank;
   logic [LABEL_WIDTH-1:0]        wr_off;

   // Ready is withheld during reset so nothing is accepted on a reset edge.
   assign in_ready = (state_q == FILL) && !rst;
   assign accept   = in_valid && in_ready;
   assign wr_bank  = wr_cnt_q[ADDR_WIDTH-1 -: 2];
   assign wr_off   = wr_cnt_q[LABEL_WIDTH-1:0];

   // Next-state logic. Writes happen only in FILL and reads only in DRAIN,
   // so frame k+1's first bank-0 write can never collide with a frame-k read.
   // The counters are exactly log2 wide, so they wrap to 0 on their own.
   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      err_d    = err_q;
      valid_d  = 1'b0;
      done_d   = 1'b0;
      lable_d  = '0;
      for (int k = 0; k < 4; k++) begin
         xr_d[k] = '0;
         xi_d[k] = '0;
      end
      case (state_q)
         FILL: begin
            if (accept) begin
               wr_cnt_d = wr_cnt_q + 1'b1;
               if (in_last != (wr_cnt_q == WR_LAST)) begin
                  err_d = 1'b1;
               end
               if (wr_cnt_q == WR_LAST) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            valid_d  = 1'b1;
            lable_d  = rd_cnt_q;
            done_d   = (rd_cnt_q == RD_LAST);
            rd_cnt_d = rd_cnt_q + 1'b1;
            for (int k = 0; k < 4; k++) begin
               {xr_d[k], xi_d[k]} = bank_mem[k][rd_cnt_q];
            end
            if (rd_cnt_q == RD_LAST) begin
               state_d = FILL;
            end
         end
      endcase
   end

   // State, counters and the registered output stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FILL;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         lable_q  <= '0;
         for (int k = 0; k < 4; k++) begin
            xr_q[k] <= '0;
            xi_q[k] <= '0;
         end
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
         err_q    <= err_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
         lable_q  <= lable_d;
         for (int k = 0; k < 4; k++) begin
            xr_q[k] <= xr_d[k];
            xi_q[k] <= xi_d[k];
         end
      end
   end

   // Sample storage. Contents survive reset; a new frame simply overwrites.
   always_ff @(posedge clk) begin
      if (accept) begin
         bank_mem[wr_bank][wr_off] <= {in_r, in_i};
      end
   end

   assign x0_r       = xr_q[0];
   assign x0_i       = xi_q[0];
   assign x1_r       = xr_q[1];
   assign x1_i       = xi_q[1];
   assign x2_r       = xr_q[2];
   assign x2_i       = xi_q[2];
   assign x3_r       = xr_q[3];
   assign x3_i       = xi_q[3];
   assign lable      = lable_q;
   assign valid      = valid_q;
   assign frame_done = done_q;
   assign frame_err  = err_q;

endmodule
